dff_chain_deserializer: RTL and testbench

- Parametrised successor to the 10-channel, 12-bit DFF scan-out capture block.
- Converts NUM_CH serial DFF-chain outputs into parallel words.
- Adds per-channel expected-pattern comparison, a valid/ack handshake, sticky overrun and fragment flags, a saturating word counter, and selectable bit order.
- Sits between the 12nm DUT scan-out pins and the host readout logic.

---
 rtl/dff_test_pkg.sv | 21 ++
 rtl/dff_chan_shifter.sv | 61 ++++++
 rtl/dff_chain_deserializer.sv | 128 ++++++++++++
 tb/tb_dff_chain_deserializer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dff_test_pkg.sv
// Shared constants and helpers for the DFF scan-chain deserializer.
// Defaults match the original 10-channel, 12-bit capture block.
package dff_test_pkg;

  localparam int NUM_CH_DEF = 10;
  localparam int WORD_W_DEF = 12;

  // Bits needed to count 0..n-1
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dff_chan_shifter.sv
// One serial channel: word assembly, output word and
// compare against the reference pattern.
module dff_chan_shifter
  import dff_test_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int MSB_FIRST = 0,
  parameter int BW        = clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap,
  input  logic              last,
  input  logic              abort,
  input  logic [BW-1:0]     bit_cnt,
  input  logic              q_bit,
  input  logic [WORD_W-1:0] expected,
  output logic [WORD_W-1:0] word_q,
  output logic              err_q
);

  localparam logic [BW-1:0] TOP = BW'(WORD_W - 1);

  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] asm_d;
  logic [WORD_W-1:0] word_d;
  logic              err_d;
  logic [BW-1:0]     idx;

  // Place the sampled bit, publish the word on the last bit
  always_comb begin
    asm_d  = asm_q;
    word_d = word_q;
    err_d  = err_q;
    idx    = (MSB_FIRST != 0) ? (TOP - bit_cnt) : bit_cnt;
    if (cap) begin
      asm_d[idx] = q_bit;
    end
    if (last) begin
      word_d = asm_d;
      err_d  = (asm_d != expected);
      asm_d  = '0;
    end else if (abort) begin
      asm_d = '0;
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q  <= '0;
      word_q <= '0;
      err_q  <= 1'b0;
    end else begin
      asm_q  <= asm_d;
      word_q <= word_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: rtl/dff_chain_deserializer.sv
// Deserializes NUM_CH DFF-chain scan outputs into parallel
// words with handshake, sticky flags and a word counter.
module dff_chain_deserializer
  import dff_test_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int WORD_W    = WORD_W_DEF,
  parameter int MSB_FIRST = 0,
  parameter int WCNT_W    = 16
) (
  input  logic                     shift_clk,
  input  logic                     RST,
  input  logic                     load,
  input  logic [NUM_CH-1:0]        q,
  input  logic [WORD_W-1:0]        expected,
  input  logic                     data_ack,
  input  logic                     clr,
  output logic [NUM_CH*WORD_W-1:0] data_out,
  output logic                     data_valid,
  output logic [NUM_CH-1:0]        err_mask,
  output logic                     err_any,
  output logic [WCNT_W-1:0]        word_count,
  output logic                     overrun,
  output logic                     frag
);

  localparam int BW = clog2(WORD_W);
  localparam logic [BW-1:0] LAST = BW'(WORD_W - 1);

  logic [BW-1:0]     bit_cnt_q;
  logic [BW-1:0]     bit_cnt_d;
  logic              valid_q;
  logic              valid_d;
  logic              overrun_q;
  logic              overrun_d;
  logic              frag_q;
  logic              frag_d;
  logic [WCNT_W-1:0] wcnt_q;
  logic [WCNT_W-1:0] wcnt_d;
  logic              cap;
  logic              last;
  logic              abort;

  assign cap   = ~load;
  assign last  = cap && (bit_cnt_q == LAST);
  assign abort = load && (bit_cnt_q != '0);

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      dff_chan_shifter #(
        .WORD_W    (WORD_W),
        .MSB_FIRST (MSB_FIRST),
        .BW        (BW)
      ) u_shf (
        .clk      (shift_clk),
        .rst_n    (RST),
        .cap      (cap),
        .last     (last),
        .abort    (abort),
        .bit_cnt  (bit_cnt_q),
        .q_bit    (q[c]),
        .expected (expected),
        .word_q   (data_out[c*WORD_W +: WORD_W]),
        .err_q    (err_mask[c])
      );
    end
  endgenerate

  // Bit counter, handshake, sticky flags; set beats clr
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (last) begin
      bit_cnt_d = '0;
    end else if (cap) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
    end else if (abort) begin
      bit_cnt_d = '0;
    end

    valid_d = valid_q;
    if (valid_q && data_ack) begin
      valid_d = 1'b0;
    end
    if (last) begin
      valid_d = 1'b1;
    end

    overrun_d = clr ? 1'b0 : overrun_q;
    if (last && valid_q && !data_ack) begin
      overrun_d = 1'b1;
    end

    frag_d = clr ? 1'b0 : frag_q;
    if (abort) begin
      frag_d = 1'b1;
    end

    wcnt_d = clr ? '0 : wcnt_q;
    if (last && (wcnt_d != '1)) begin
      wcnt_d = wcnt_d + 1'b1;
    end
  end

  // Control state registers
  always_ff @(posedge shift_clk or negedge RST) begin
    if (!RST) begin
      bit_cnt_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      frag_q    <= 1'b0;
      wcnt_q    <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      frag_q    <= frag_d;
      wcnt_q    <= wcnt_d;
    end
  end

  assign data_valid = valid_q;
  assign overrun    = overrun_q;
  assign frag       = frag_q;
  assign word_count = wcnt_q;
  assign err_any    = |err_mask;

endmodule

// File: tb/tb_dff_chain_deserializer.sv
// Directed bench: LSB-first, MSB-first and 4-bit-counter
// instances share one stimulus stream.
module tb_dff_chain_deserializer;

  localparam int NC = 10;
  localparam int W  = 12;

  logic          shift_clk = 1'b0;
  logic          RST;
  logic          load;
  logic [NC-1:0] q;
  logic [W-1:0]  expected;
  logic          data_ack;
  logic          clr;

  logic [NC*W-1:0] d0_out, d1_out, d2_out;
  logic            d0_vld, d1_vld, d2_vld;
  logic [NC-1:0]   d0_err, d1_err, d2_err;
  logic            d0_any, d1_any, d2_any;
  logic [15:0]     d0_cnt, d1_cnt;
  logic [3:0]      d2_cnt;
  logic            d0_ovr, d1_ovr, d2_ovr;
  logic            d0_frg, d1_frg, d2_frg;

  int n_cmp = 0;
  int n_err = 0;

  always #5 shift_clk = ~shift_clk;

  dff_chain_deserializer #(
    .NUM_CH(NC), .WORD_W(W), .MSB_FIRST(0), .WCNT_W(16)
  ) dut0 (
    .shift_clk(shift_clk), .RST(RST), .load(load), .q(q),
    .expected(expected), .data_ack(data_ack), .clr(clr),
    .data_out(d0_out), .data_valid(d0_vld), .err_mask(d0_err),
    .err_any(d0_any), .word_count(d0_cnt), .overrun(d0_ovr),
    .frag(d0_frg)
  );

  dff_chain_deserializer #(
    .NUM_CH(NC), .WORD_W(W), .MSB_FIRST(1), .WCNT_W(16)
  ) dut1 (
    .shift_clk(shift_clk), .RST(RST), .load(load), .q(q),
    .expected(expected), .data_ack(data_ack), .clr(clr),
    .data_out(d1_out), .data_valid(d1_vld), .err_mask(d1_err),
    .err_any(d1_any), .word_count(d1_cnt), .overrun(d1_ovr),
    .frag(d1_frg)
  );

  dff_chain_deserializer #(
    .NUM_CH(NC), .WORD_W(W), .MSB_FIRST(0), .WCNT_W(4)
  ) dut2 (
    .shift_clk(shift_clk), .RST(RST), .load(load), .q(q),
    .expected(expected), .data_ack(data_ack), .clr(clr),
    .data_out(d2_out), .data_valid(d2_vld), .err_mask(d2_err),
    .err_any(d2_any), .word_count(d2_cnt), .overrun(d2_ovr),
    .frag(d2_frg)
  );

  function automatic logic [W-1:0] bitrev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  // Channel c carries base ^ c
  function automatic logic [NC*W-1:0] exp_vec(
    input logic [W-1:0] base, input logic rev);
    logic [NC*W-1:0] v;
    logic [W-1:0]    w;
    for (int c = 0; c < NC; c++) begin
      w = base ^ W'(c);
      v[c*W +: W] = rev ? bitrev(w) : w;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge shift_clk);
    #1;
  endtask

  task automatic send_bits(input logic [W-1:0] base, input int first,
                           input int nbits, input logic ack_last,
                           input logic clr_last);
    logic [W-1:0] wv;
    for (int i = first; i < first + nbits; i++) begin
      for (int c = 0; c < NC; c++) begin
        wv = base ^ W'(c);
        q[c] = wv[i];
      end
      load = 1'b0;
      data_ack = (i == first + nbits - 1) ? ack_last : 1'b0;
      clr = (i == first + nbits - 1) ? clr_last : 1'b0;
      tick();
    end
    load = 1'b1;
    data_ack = 1'b0;
    clr = 1'b0;
    q = '0;
  endtask

  task automatic ack_clr();
    data_ack = 1'b1;
    clr = 1'b1;
    tick();
    data_ack = 1'b0;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    load = 1'b1;
    q = '0;
    expected = 12'hA5C;
    data_ack = 1'b0;
    clr = 1'b0;
    #12;
    if (d0_out !== '0) begin n_err++; $display("FAIL rst_data got %h want 0", d0_out); end n_cmp++;
    if ({d0_vld, d0_any, d0_ovr, d0_frg} !== 4'b0) begin n_err++; $display("FAIL rst_flags got %b want 0000", {d0_vld, d0_any, d0_ovr, d0_frg}); end n_cmp++;
    if (d0_err !== '0 || d0_cnt !== '0) begin n_err++; $display("FAIL rst_cnt err=%h cnt=%h want 0", d0_err, d0_cnt); end n_cmp++;
    RST = 1'b1;
  endtask

  task automatic test_lsb_msb();
    send_bits(12'hA5C, 0, 11, 1'b0, 1'b0);
    load = 1'b0;
    if (d0_vld !== 1'b0) begin n_err++; $display("FAIL early_valid got %b want 0", d0_vld); end n_cmp++;
    send_bits(12'hA5C, 11, 1, 1'b0, 1'b0);
    if (d0_vld !== 1'b1) begin n_err++; $display("FAIL lsb_valid got %b want 1", d0_vld); end n_cmp++;
    if (d0_out !== exp_vec(12'hA5C, 1'b0)) begin n_err++; $display("FAIL lsb_data got %h want %h", d0_out, exp_vec(12'hA5C, 1'b0)); end n_cmp++;
    if (d0_err !== 10'h3FE || d0_any !== 1'b1) begin n_err++; $display("FAIL lsb_err got %h/%b want 3fe/1", d0_err, d0_any); end n_cmp++;
    if (d0_cnt !== 16'd1) begin n_err++; $display("FAIL lsb_cnt got %0d want 1", d0_cnt); end n_cmp++;
    if (d1_out !== exp_vec(12'hA5C, 1'b1)) begin n_err++; $display("FAIL msb_data got %h want %h", d1_out, exp_vec(12'hA5C, 1'b1)); end n_cmp++;
    if (d1_err !== 10'h3FF) begin n_err++; $display("FAIL msb_err got %h want 3ff", d1_err); end n_cmp++;
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    if (d0_vld !== 1'b0) begin n_err++; $display("FAIL ack_clear got %b want 0", d0_vld); end n_cmp++;
    tick();
    if (d0_vld !== 1'b0 || d0_ovr !== 1'b0) begin n_err++; $display("FAIL idle vld=%b ovr=%b want 0/0", d0_vld, d0_ovr); end n_cmp++;
  endtask

  task automatic test_back_to_back();
    ack_clr();
    expected = 12'h456;
    send_bits(12'h123, 0, W, 1'b0, 1'b0);
    if (d0_ovr !== 1'b0) begin n_err++; $display("FAIL b2b_first_ovr got %b want 0", d0_ovr); end n_cmp++;
    send_bits(12'h456, 0, W, 1'b0, 1'b0);
    if (d0_ovr !== 1'b1) begin n_err++; $display("FAIL b2b_ovr got %b want 1", d0_ovr); end n_cmp++;
    if (d0_out !== exp_vec(12'h456, 1'b0)) begin n_err++; $display("FAIL b2b_data got %h want %h", d0_out, exp_vec(12'h456, 1'b0)); end n_cmp++;
    if (d0_err !== 10'h3FE || d0_cnt !== 16'd2) begin n_err++; $display("FAIL b2b_err got %h cnt %0d want 3fe/2", d0_err, d0_cnt); end n_cmp++;
    ack_clr();
    send_bits(12'h789, 0, W, 1'b0, 1'b0);
    send_bits(12'h456, 0, W, 1'b1, 1'b0);
    if (d0_ovr !== 1'b0 || d0_vld !== 1'b1) begin n_err++; $display("FAIL ackcomp ovr=%b vld=%b want 0/1", d0_ovr, d0_vld); end n_cmp++;
    if (d0_out !== exp_vec(12'h456, 1'b0)) begin n_err++; $display("FAIL ackcomp_data got %h want %h", d0_out, exp_vec(12'h456, 1'b0)); end n_cmp++;
  endtask

  task automatic test_frag();
    ack_clr();
    expected = 12'hA5C;
    send_bits(12'hFFF, 0, 5, 1'b0, 1'b0);
    tick();
    if (d0_frg !== 1'b1) begin n_err++; $display("FAIL frag_set got %b want 1", d0_frg); end n_cmp++;
    if (d0_vld !== 1'b0 || d0_out !== exp_vec(12'h456, 1'b0)) begin n_err++; $display("FAIL frag_keep vld=%b data=%h", d0_vld, d0_out); end n_cmp++;
    send_bits(12'h3C7, 0, W, 1'b0, 1'b0);
    if (d0_out !== exp_vec(12'h3C7, 1'b0)) begin n_err++; $display("FAIL frag_data got %h want %h", d0_out, exp_vec(12'h3C7, 1'b0)); end n_cmp++;
    if (d0_cnt !== 16'd1 || d0_frg !== 1'b1) begin n_err++; $display("FAIL frag_cnt cnt=%0d frag=%b want 1/1", d0_cnt, d0_frg); end n_cmp++;
  endtask

  task automatic test_async_reset();
    send_bits(12'h555, 0, 7, 1'b0, 1'b0);
    load = 1'b0;
    #3;
    RST = 1'b0;
    #1;
    if (d0_out !== '0 || d0_vld !== 1'b0) begin n_err++; $display("FAIL arst_data vld=%b data=%h want 0", d0_vld, d0_out); end n_cmp++;
    if (d0_cnt !== '0 || d0_frg !== 1'b0 || d0_err !== '0) begin n_err++; $display("FAIL arst_flags cnt=%0d frag=%b err=%h want 0", d0_cnt, d0_frg, d0_err); end n_cmp++;
    load = 1'b1;
    #2;
    RST = 1'b1;
    send_bits(12'h0F0, 0, W, 1'b0, 1'b0);
    if (d0_out !== exp_vec(12'h0F0, 1'b0) || d0_cnt !== 16'd1) begin n_err++; $display("FAIL arst_next data=%h cnt=%0d want %h/1", d0_out, d0_cnt, exp_vec(12'h0F0, 1'b0)); end n_cmp++;
    if (d0_err !== 10'h3FF) begin n_err++; $display("FAIL arst_err got %h want 3ff", d0_err); end n_cmp++;
  endtask

  task automatic test_saturate_clr();
    ack_clr();
    for (int k = 0; k < 15; k++) begin
      send_bits(W'(k), 0, W, 1'b0, 1'b0);
    end
    if (d2_cnt !== 4'hF || d0_cnt !== 16'd15) begin n_err++; $display("FAIL sat_reach d2=%h d0=%0d want f/15", d2_cnt, d0_cnt); end n_cmp++;
    send_bits(12'h111, 0, W, 1'b0, 1'b0);
    if (d2_cnt !== 4'hF) begin n_err++; $display("FAIL sat_hold got %h want f", d2_cnt); end n_cmp++;
    if (d0_cnt !== 16'd16) begin n_err++; $display("FAIL sat_wide got %0d want 16", d0_cnt); end n_cmp++;
    send_bits(12'h222, 0, 3, 1'b0, 1'b0);
    tick();
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    if (d0_frg !== 1'b1 || d0_ovr !== 1'b1 || d0_vld !== 1'b0) begin n_err++; $display("FAIL pre_clr frag=%b ovr=%b vld=%b want 1/1/0", d0_frg, d0_ovr, d0_vld); end n_cmp++;
    send_bits(12'h333, 0, W, 1'b0, 1'b1);
    if (d0_cnt !== 16'd1 || d2_cnt !== 4'd1) begin n_err++; $display("FAIL clr_cnt d0=%0d d2=%0d want 1/1", d0_cnt, d2_cnt); end n_cmp++;
    if (d0_ovr !== 1'b0 || d0_frg !== 1'b0) begin n_err++; $display("FAIL clr_flags ovr=%b frag=%b want 0/0", d0_ovr, d0_frg); end n_cmp++;
    send_bits(12'h444, 0, W, 1'b0, 1'b1);
    if (d0_ovr !== 1'b1 || d0_cnt !== 16'd1) begin n_err++; $display("FAIL clr_set ovr=%b cnt=%0d want 1/1", d0_ovr, d0_cnt); end n_cmp++;
    if (d0_out !== exp_vec(12'h444, 1'b0)) begin n_err++; $display("FAIL clr_data got %h want %h", d0_out, exp_vec(12'h444, 1'b0)); end n_cmp++;
  endtask

  initial begin
    test_reset();
    test_lsb_msb();
    test_back_to_back();
    test_frag();
    test_async_reset();
    test_saturate_clr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
